uart_byte_rx: RTL and testbench
===============================

Name: uart_byte_rx

Overview:
- Serial-to-byte front end for the byte-sequence detector.
- Recovers 8N1 asynchronous serial frames from a single input line, oversampled by the system clock.
- Presents each received byte on a parallel bus with a one-cycle valid strobe and holds it until the next good frame.
- Sits directly upstream of the detector: data drives the detector's 8-bit input.

Parameters:
- CLKS_PER_BIT, 16, system clocks per serial bit. Legal range is 4 to 65535. HALF = CLKS_PER_BIT/2, using integer division.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idles high; asynchronous to clock.
- data  output  8  last correctly framed byte; held between frames.
- valid  output  1  one-cycle pulse when data updates.
- framing_err  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - data=8'h00, valid=0, framing_err=0, busy=0.
  - State=IDLE; bit counter and tick counter cleared.
  - Both synchronizer flops are forced to 1, so the line reads idle.
- Synchronizer:
  - rx passes through two flops to give rx_s; 2-cycle latency.
  - Only rx_s is used internally.
- Definition: t0 is the first cycle in IDLE where rx_s==0.
- Sampling:
  - rx_s is sampled at t0 + HALF + k*CLKS_PER_BIT.
  - k=0 is the start bit, k=1..8 are data bits (LSB first), k=9 is the stop bit.
- States:
  - IDLE: wait for rx_s==0, then go to START and clear the tick counter.
  - START: at sample k=0, if rx_s==1 it is a false start; return to IDLE with no outputs. Otherwise go to DATA.
  - DATA: at each sample, shift rx_s into bit[k-1]. After 8 bits, go to STOP.
  - STOP, rx_s==1: data <= assembled byte, valid=1 for the next cycle only, then IDLE.
  - STOP, rx_s==0: framing_err=1 for one cycle; data unchanged; no valid; go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. A line held low never produces further frames or error pulses.
- Latency:
  - valid/framing_err are high in cycle t0 + HALF + 9*CLKS_PER_BIT + 1.
  - With default parameters this is t0+153, i.e. 155 cycles after the rx pin falls.
- Back-to-back frames: a start bit immediately following the stop bit must be accepted. IDLE is re-entered before the next falling edge reaches rx_s.
- Outputs:
  - valid and framing_err are never high in the same cycle.
  - valid is never high on two consecutive cycles.
  - data changes only in the cycle valid rises.
- Reset mid-frame: the frame is abandoned immediately with all outputs at reset values. Reception restarts on the next falling edge after reset is released.
- Counters:
  - Tick counter width is $clog2(CLKS_PER_BIT); it wraps to 0 at CLKS_PER_BIT-1.
  - Bit counter is 4 bits.
  - No counter may overflow silently.

Test Plan:
- Clean frame for 0x1F (default params, rx pin falls at cycle p) -> valid high only in cycle p+155; data=8'h1F from then on; framing_err stays 0; busy high p+3..p+155.
- Three back-to-back frames 0xB2, 0x3C, 0xA5 with zero idle time between frames -> exactly three valid pulses, 160 cycles apart; data sequence B2, 3C, A5.
- Glitch: rx low for 3 cycles then high -> START aborts at its k=0 sample; no valid, no framing_err; busy returns to 0; a following 0x55 frame is received correctly.
- Framing error: send 0x3C with stop bit 0, then hold rx low 500 cycles, then release -> one framing_err pulse; data keeps the prior value (8'h1F); no further pulses while low; next 0x1F frame is accepted.
- Reset mid-frame: assert reset during bit 4 of 0xFF -> data=00, outputs 0 asynchronously; after release, frame 0xC3 gives data=8'hC3 with one valid.
- CLKS_PER_BIT=5 (odd, HALF=2): frame 0x81 -> valid at t0+48; data=8'h81.

Source files
------------

// File: rtl/uart_byte_rx.sv
// 8N1 serial receiver: recovers bytes from an oversampled rx line
// and presents them with a one-cycle valid strobe.
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_err,
    output logic       busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TW   = $clog2(CLKS_PER_BIT);

    localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);
    localparam logic [TW-1:0] LAST    = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state;
    logic [TW-1:0] tick;
    logic [3:0]    bitcnt;
    logic [7:0]    shreg;
    logic          rx_m;
    logic          rx_s;

    // Both stages reset high so the line reads idle out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tick        <= '0;
            bitcnt      <= '0;
            shreg       <= '0;
            data        <= '0;
            valid       <= 1'b0;
            framing_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            valid       <= 1'b0;
            framing_err <= 1'b0;
            case (state)
                IDLE: begin
                    tick   <= '0;
                    bitcnt <= '0;
                    // Busy trails the state by one cycle on the way out.
                    busy   <= ~rx_s;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (tick == HALF_M1) begin
                        tick  <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                DATA: begin
                    if (tick == LAST) begin
                        tick   <= '0;
                        shreg  <= {rx_s, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 4'd7) begin
                            bitcnt <= '0;
                            state  <= STOP;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                STOP: begin
                    if (tick == LAST) begin
                        tick <= '0;
                        if (rx_s) begin
                            data  <= shreg;
                            valid <= 1'b1;
                            state <= IDLE;
                        end else begin
                            framing_err <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed plus randomized frames against a frame-level timing model,
// for a 16-clock and a 5-clock instance of the receiver.
module tb_uart_byte_rx;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx5 = 1'b1;
    logic [7:0] data, data5;
    logic       valid, valid5, ferr, ferr5, busy, busy5;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    uart_byte_rx #(.CLKS_PER_BIT(16)) dut (
        .clock(clock), .reset(rst_n), .rx(rx), .data(data),
        .valid(valid), .framing_err(ferr), .busy(busy)
    );

    uart_byte_rx #(.CLKS_PER_BIT(5)) dut5 (
        .clock(clock), .reset(rst_n), .rx(rx5), .data(data5),
        .valid(valid5), .framing_err(ferr5), .busy(busy5)
    );

    int         vt0[$], ft0[$], vt5[$], ft5[$], br[$], bf[$];
    logic [7:0] vd0[$], vd5[$];
    int         et0[$], ef0[$], et5[$], ef5[$];
    logic [7:0] ed0[$], ed5[$];
    logic [7:0] last0 = 8'h00;
    logic [7:0] last5 = 8'h00;

    logic       busy_q = 1'b0, rst_q = 1'b0;
    logic       valid_q = 1'b0, valid5_q = 1'b0;
    logic [7:0] data_q = 8'h00, data5_q = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (valid) begin
            vt0.push_back(cyc);
            vd0.push_back(data);
        end
        if (ferr) ft0.push_back(cyc);
        if (valid5) begin
            vt5.push_back(cyc);
            vd5.push_back(data5);
        end
        if (ferr5) ft5.push_back(cyc);
        if (busy && !busy_q) br.push_back(cyc);
        if (!busy && busy_q) bf.push_back(cyc);
        if (rst_n && rst_q) begin
            chk("excl16", {31'b0, valid & ferr}, 0);
            chk("excl5", {31'b0, valid5 & ferr5}, 0);
            chk("dblv16", {31'b0, valid & valid_q}, 0);
            chk("dblv5", {31'b0, valid5 & valid5_q}, 0);
            chk("dchg16", {31'b0, (data != data_q) & ~valid}, 0);
            chk("dchg5", {31'b0, (data5 != data5_q) & ~valid5}, 0);
        end
        busy_q   <= busy;
        rst_q    <= rst_n;
        valid_q  <= valid;
        valid5_q <= valid5;
        data_q   <= data;
        data5_q  <= data5;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int ch, input logic v);
        if (ch == 0) rx = v;
        else rx5 = v;
    endtask

    // Valid/error appears 2 sync cycles + half bit + 9 bits + 1 after the pin falls.
    task automatic send(input int ch, input logic [7:0] b,
                        input logic stopv, output int p);
        int         cpb;
        int         lat;
        logic [9:0] fr;
        cpb = (ch == 0) ? 16 : 5;
        lat = 3 + cpb / 2 + 9 * cpb;
        fr  = {stopv, b, 1'b0};
        p   = cyc;
        for (int i = 0; i < 10; i++) begin
            drive(ch, fr[i]);
            repeat (cpb) tick();
        end
        if (ch == 0) begin
            if (stopv) begin
                et0.push_back(p + lat);
                ed0.push_back(b);
                last0 = b;
            end else ef0.push_back(p + lat);
        end else begin
            if (stopv) begin
                et5.push_back(p + lat);
                ed5.push_back(b);
                last5 = b;
            end else ef5.push_back(p + lat);
        end
    endtask

    task automatic verify(input int ch, input string tag);
        int         at[$], af[$], xt[$], xf[$];
        logic [7:0] ad[$], xd[$];
        logic [7:0] dq, lg;
        if (ch == 0) begin
            at = vt0; ad = vd0; af = ft0;
            xt = et0; xd = ed0; xf = ef0;
            dq = data; lg = last0;
            vt0.delete(); vd0.delete(); ft0.delete();
            et0.delete(); ed0.delete(); ef0.delete();
        end else begin
            at = vt5; ad = vd5; af = ft5;
            xt = et5; xd = ed5; xf = ef5;
            dq = data5; lg = last5;
            vt5.delete(); vd5.delete(); ft5.delete();
            et5.delete(); ed5.delete(); ef5.delete();
        end
        chk({tag, "_nvalid"}, at.size(), xt.size());
        for (int i = 0; i < at.size() && i < xt.size(); i++) begin
            chk({tag, "_vtime"}, at[i], xt[i]);
            chk({tag, "_vdata"}, {24'b0, ad[i]}, {24'b0, xd[i]});
        end
        chk({tag, "_nferr"}, af.size(), xf.size());
        for (int i = 0; i < af.size() && i < xf.size(); i++) begin
            chk({tag, "_ftime"}, af[i], xf[i]);
        end
        chk({tag, "_data"}, {24'b0, dq}, {24'b0, lg});
    endtask

    task automatic rand_frames(input int ch, input int n);
        int         p;
        logic [7:0] b;
        logic       bad;
        for (int i = 0; i < n; i++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            send(ch, b, ~bad, p);
            if (bad) begin
                repeat ($urandom_range(0, 30)) tick();
                drive(ch, 1'b1);
                repeat ($urandom_range(3, 10)) tick();
            end else begin
                repeat ($urandom_range(0, 8)) tick();
            end
        end
        repeat (4) tick();
    endtask

    initial begin
        int p;

        repeat (3) tick();
        chk("rst_data", {24'b0, data}, 0);
        chk("rst_valid", {31'b0, valid}, 0);
        chk("rst_ferr", {31'b0, ferr}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_data5", {24'b0, data5}, 0);
        chk("rst_busy5", {31'b0, busy5}, 0);
        rst_n = 1'b1;
        repeat (5) tick();

        br.delete(); bf.delete();
        send(0, 8'h1F, 1'b1, p);
        repeat (4) tick();
        chk("clean_nrise", br.size(), 1);
        chk("clean_nfall", bf.size(), 1);
        if (br.size() > 0) chk("clean_brise", br[0], p + 3);
        if (bf.size() > 0) chk("clean_bfall", bf[0], p + 156);
        verify(0, "clean");

        send(0, 8'h3C, 1'b0, p);
        repeat (500) tick();
        drive(0, 1'b1);
        repeat (20) tick();
        chk("break_busy", {31'b0, busy}, 0);
        verify(0, "ferr");
        send(0, 8'h1F, 1'b1, p);
        repeat (4) tick();
        verify(0, "after_ferr");

        send(0, 8'hB2, 1'b1, p);
        send(0, 8'h3C, 1'b1, p);
        send(0, 8'hA5, 1'b1, p);
        repeat (4) tick();
        verify(0, "b2b");

        drive(0, 1'b0);
        repeat (3) tick();
        drive(0, 1'b1);
        repeat (30) tick();
        chk("glitch_busy", {31'b0, busy}, 0);
        verify(0, "glitch");
        send(0, 8'h55, 1'b1, p);
        repeat (4) tick();
        verify(0, "after_glitch");

        drive(0, 1'b0);
        repeat (16) tick();
        drive(0, 1'b1);
        repeat (72) tick();
        chk("mid_busy", {31'b0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_data", {24'b0, data}, 0);
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_valid", {31'b0, valid}, 0);
        chk("arst_ferr", {31'b0, ferr}, 0);
        last0 = 8'h00;
        repeat (4) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        verify(0, "midrst");
        send(0, 8'hC3, 1'b1, p);
        repeat (4) tick();
        verify(0, "after_rst");

        rand_frames(0, 12);
        verify(0, "rand16");

        send(1, 8'h81, 1'b1, p);
        repeat (4) tick();
        verify(1, "cpb5");
        rand_frames(1, 10);
        verify(1, "rand5");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
